// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions: tag layout, opcode/target encodings and line geometry.
// Used by both the initiator side and the memory responder.
package sysbus_pkg;

  localparam int LINE_BYTES = 64;
  localparam int BEATS      = 8;

  localparam logic       READ   = 1'b1;
  localparam logic       WRITE  = 1'b0;
  localparam logic [3:0] MEMORY = 4'b0001;

  typedef struct packed {
    logic       wr;
    logic [3:0] t;
    logic [7:0] priv;
  } sysbus_tag_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACK      = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_RD_BURST = 3'd3,
    ST_WR_DATA  = 3'd4
  } rsp_state_e;

endpackage

// File: rtl/sysbus_mem_array.sv
// Single-port 64-bit word store indexed {line, word}; one-cycle synchronous read,
// synchronous write. Contents are never cleared.
module sysbus_mem_array #(
  parameter int DEPTH = 32768,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [63:0]   i_wdata,
  output logic [63:0]   o_rdata
);

  logic [63:0] r_mem [DEPTH];
  logic [63:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory-side responder: acknowledges address beats, returns 8-beat read lines
// or absorbs 8-beat write lines. Optional macro SYSBUS_MEM_CRIT_WORD_FIRST_EN.
//
// Handshake: reqack is a one-cycle pulse in the cycle after an accepted address beat;
// a read beat transfers on a rising edge where respcyc && respack, and resp/resptag/respcyc
// hold while respack is low; a write beat transfers on each edge in WR_DATA with reqcyc high.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int LINES  = 4096,
  parameter int RD_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqcyc,
  input  logic [63:0] req,
  input  logic [12:0] reqtag,
  output logic        reqack,
  output logic        respcyc,
  output logic [63:0] resp,
  output logic [12:0] resptag,
  input  logic        respack,
  output rsp_state_e  o_dbg_state
);

  localparam int LINE_W   = $clog2(LINES);
  localparam int AW       = LINE_W + 3;
  localparam int LAT_LAST = (RD_LAT > 1) ? RD_LAT - 2 : 0;
  localparam int LAT_W    = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

  rsp_state_e  r_state, w_state_nxt;
  logic [LINE_W-1:0] r_line;
  sysbus_tag_t r_tag;
  logic [2:0]  r_word, w_word_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [LAT_W-1:0] r_lat, w_lat_nxt;
  logic        w_capture;
  logic        w_mem_we;
  logic [2:0]  w_mem_word;
  logic [2:0]  w_start_word;
  logic [63:0] w_rdata;
  logic        w_is_mem;

`ifdef SYSBUS_MEM_CRIT_WORD_FIRST_EN
  assign w_start_word = req[5:3];
`else
  assign w_start_word = 3'd0;
`endif

  assign w_is_mem = (r_tag.t == MEMORY);

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_cnt_nxt   = r_cnt;
    w_lat_nxt   = r_lat;
    w_capture   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_word  = r_word;
    case (r_state)
      ST_IDLE: begin
        if (reqcyc) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_ACK;
          w_cnt_nxt   = 3'd0;
          w_lat_nxt   = '0;
          w_word_nxt  = (reqtag[12] == READ) ? w_start_word : 3'd0;
        end
      end
      ST_ACK: begin
        if (r_tag.wr == READ) w_state_nxt = (RD_LAT == 1) ? ST_RD_BURST : ST_RD_WAIT;
        else                  w_state_nxt = ST_WR_DATA;
      end
      ST_RD_WAIT: begin
        if (r_lat == LAT_W'(LAT_LAST)) w_state_nxt = ST_RD_BURST;
        else                           w_lat_nxt   = r_lat + LAT_W'(1);
      end
      ST_RD_BURST: begin
        // Look ahead on acceptance so the next word is in the RAM register at the edge.
        if (respack) begin
          w_mem_word = r_word + 3'd1;
          w_word_nxt = r_word + 3'd1;
          if (r_cnt == 3'd7) w_state_nxt = ST_IDLE;
          else               w_cnt_nxt   = r_cnt + 3'd1;
        end
      end
      ST_WR_DATA: begin
        if (reqcyc) begin
          w_mem_we   = w_is_mem;
          w_word_nxt = r_word + 3'd1;
          if (r_cnt == 3'd7) w_state_nxt = ST_IDLE;
          else               w_cnt_nxt   = r_cnt + 3'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_line <= '0;
      r_tag  <= '0;
      r_word <= 3'd0;
      r_cnt  <= 3'd0;
      r_lat  <= '0;
    end else begin
      r_word <= w_word_nxt;
      r_cnt  <= w_cnt_nxt;
      r_lat  <= w_lat_nxt;
      if (w_capture) begin
        r_line <= req[6 +: LINE_W];
        r_tag  <= sysbus_tag_t'(reqtag);
      end
    end
  end

  sysbus_mem_array #(
    .DEPTH (LINES * BEATS),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  ({r_line, w_mem_word}),
    .i_wdata (req),
    .o_rdata (w_rdata)
  );

  // Non-memory targets read as zero; outside a burst resp is forced to zero.
  assign reqack      = (r_state == ST_ACK);
  assign respcyc     = (r_state == ST_RD_BURST);
  assign resp        = (respcyc && w_is_mem) ? w_rdata : 64'd0;
  assign resptag     = r_tag;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder: vector table of line writes/reads checked
// against a word-level reference store, plus a reset-mid-burst sequence.
module tb_sysbus_mem_responder;
  import sysbus_pkg::*;

  localparam int LINES  = 4096;
  localparam int RD_LAT = 4;

  logic        clk;
  logic        reset;
  logic        reqcyc;
  logic [63:0] req;
  logic [12:0] reqtag;
  logic        reqack;
  logic        respcyc;
  logic [63:0] resp;
  logic [12:0] resptag;
  logic        respack;
  rsp_state_e  dbg_state;

  int checks;
  int failures;

  logic [63:0] exp_q[$];
  logic [63:0] model_mem [int];

  typedef struct {
    logic        wr;
    logic [3:0]  t;
    logic [63:0] addr;
    logic [7:0]  priv;
    logic [63:0] base;
    int          stall_at;
    int          stall_len;
    logic [63:0] exp_first;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[11];

  sysbus_mem_responder #(
    .LINES  (LINES),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .reqcyc      (reqcyc),
    .req         (req),
    .reqtag      (reqtag),
    .reqack      (reqack),
    .respcyc     (respcyc),
    .resp        (resp),
    .resptag     (resptag),
    .respack     (respack),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int start_word(input logic [63:0] addr);
    logic [63:0] a;
    a = addr;
`ifdef SYSBUS_MEM_CRIT_WORD_FIRST_EN
    return int'(a[5:3]);
`else
    return 0;
`endif
  endfunction

  function automatic int line_of(input logic [63:0] addr);
    return int'((addr >> 6) & 64'(LINES - 1));
  endfunction

  // driver: write line
  task automatic do_write(input string name, input logic [3:0] t, input logic [63:0] addr,
                          input logic [7:0] priv, input logic [63:0] base,
                          input int stall_at, input int stall_len);
    reqcyc = 1'b1;
    req    = addr;
    reqtag = {WRITE, t, priv};
    @(negedge clk);
    chk({name, ".reqack"}, 64'(reqack), 64'd1);
    reqcyc = 1'b0;
    req    = '0;
    @(negedge clk);
    chk({name, ".reqack_drop"}, 64'(reqack), 64'd0);
    for (int k = 0; k < BEATS; k++) begin
      if (k == stall_at) begin
        reqcyc = 1'b0;
        repeat (stall_len) @(negedge clk);
      end
      reqcyc = 1'b1;
      req    = base * 64'(k + 1);
      @(negedge clk);
    end
    reqcyc = 1'b0;
    req    = '0;
    chk({name, ".idle"}, 64'(dbg_state), 64'(ST_IDLE));
    chk({name, ".no_resp"}, 64'(respcyc), 64'd0);
    if (t == MEMORY)
      for (int k = 0; k < BEATS; k++) model_mem[line_of(addr) * 8 + k] = base * 64'(k + 1);
  endtask

  // driver + scoreboard: read line
  task automatic do_read(input string name, input logic [3:0] t, input logic [63:0] addr,
                         input logic [7:0] priv, input int stall_at, input int stall_len,
                         input logic [63:0] exp_first, input int exp_cycles, input int abort_at);
    int lat;
    int cycles;
    int beats;
    int held;
    int w;
    exp_q.delete();
    for (int k = 0; k < BEATS; k++) begin
      w = (start_word(addr) + k) % 8;
      exp_q.push_back((t == MEMORY) ? model_mem[line_of(addr) * 8 + w] : 64'd0);
    end
    reqcyc = 1'b1;
    req    = addr;
    reqtag = {READ, t, priv};
    @(negedge clk);
    chk({name, ".reqack"}, 64'(reqack), 64'd1);
    reqcyc = 1'b0;
    req    = '0;
    lat = 0;
    while (!respcyc && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({name, ".latency"}, 64'(lat), 64'(RD_LAT));
    if (!respcyc) begin
      exp_q.delete();
      return;
    end
    cycles = 0;
    beats  = 0;
    held   = 0;
    while (beats < BEATS && cycles < 64) begin
      if (beats == abort_at) begin
        reset = 1'b1;
        #1;
        chk({name, ".rst_respcyc"}, 64'(respcyc), 64'd0);
        chk({name, ".rst_reqack"}, 64'(reqack), 64'd0);
        chk({name, ".rst_resp"}, resp, 64'd0);
        chk({name, ".rst_resptag"}, 64'(resptag), 64'd0);
        exp_q.delete();
        respack = 1'b1;
        return;
      end
      chk({name, ".respcyc"}, 64'(respcyc), 64'd1);
      chk($sformatf("%s.beat%0d", name, beats), resp, exp_q[0]);
      chk({name, ".resptag"}, 64'(resptag), 64'({READ, t, priv}));
      if (beats == 0 && held == 0) chk({name, ".first"}, resp, exp_first);
      if (beats == stall_at && held < stall_len) begin
        respack = 1'b0;
        held++;
      end else begin
        respack = 1'b1;
        void'(exp_q.pop_front());
        beats++;
      end
      cycles++;
      @(negedge clk);
    end
    respack = 1'b1;
    chk({name, ".burst_cycles"}, 64'(cycles), 64'(exp_cycles));
    chk({name, ".respcyc_drop"}, 64'(respcyc), 64'd0);
    chk({name, ".leftover"}, 64'(exp_q.size()), 64'd0);
    chk({name, ".idle"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    reqcyc   = 1'b0;
    req      = '0;
    reqtag   = '0;
    respack  = 1'b1;

    //                wr     t        addr                     priv   base    stall  len  first     cyc
    vecs[0]  = '{WRITE, MEMORY,  64'h1000,                 8'h01, 64'h11,   -1,   0, 64'h0,    0};
    vecs[1]  = '{READ,  MEMORY,  64'h1000,                 8'h02, 64'h0,    -1,   0, 64'h11,   8};
    vecs[2]  = '{READ,  MEMORY,  64'h1000,                 8'h03, 64'h0,     2,   3, 64'h11,  11};
    vecs[3]  = '{WRITE, MEMORY,  64'h2000,                 8'h04, 64'h0101,  4,   2, 64'h0,    0};
    vecs[4]  = '{READ,  MEMORY,  64'h2000,                 8'h05, 64'h0,    -1,   0, 64'h0101, 8};
    vecs[5]  = '{WRITE, MEMORY,  64'(LINES * 64 + 'h40),   8'h06, 64'hA5,   -1,   0, 64'h0,    0};
    vecs[6]  = '{READ,  MEMORY,  64'h40,                   8'h07, 64'h0,    -1,   0, 64'hA5,   8};
    vecs[7]  = '{READ,  4'b0010, 64'h1000,                 8'h08, 64'h0,    -1,   0, 64'h0,    8};
    vecs[8]  = '{WRITE, 4'b0010, 64'h1000,                 8'h09, 64'hFF,   -1,   0, 64'h0,    0};
    vecs[9]  = '{READ,  MEMORY,  64'h1000,                 8'h0A, 64'h0,    -1,   0, 64'h11,   8};
`ifdef SYSBUS_MEM_CRIT_WORD_FIRST_EN
    vecs[10] = '{READ,  MEMORY,  64'h1028,                 8'h0B, 64'h0,    -1,   0, 64'h66,   8};
`else
    vecs[10] = '{READ,  MEMORY,  64'h1028,                 8'h0B, 64'h0,    -1,   0, 64'h11,   8};
`endif

    repeat (2) @(negedge clk);
    chk("reset.reqack", 64'(reqack), 64'd0);
    chk("reset.respcyc", 64'(respcyc), 64'd0);
    chk("reset.resp", resp, 64'd0);
    chk("reset.resptag", 64'(resptag), 64'd0);
    chk("reset.state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr == WRITE)
        do_write($sformatf("v%0d", i), vecs[i].t, vecs[i].addr, vecs[i].priv, vecs[i].base,
                 vecs[i].stall_at, vecs[i].stall_len);
      else
        do_read($sformatf("v%0d", i), vecs[i].t, vecs[i].addr, vecs[i].priv, vecs[i].stall_at,
                vecs[i].stall_len, vecs[i].exp_first, vecs[i].exp_cycles, -1);
    end

    // reset during beat 4, then the same line must read back intact
    do_read("abort", MEMORY, 64'h1000, 8'h0C, -1, 0, 64'h11, 8, 4);
    repeat (2) @(negedge clk);
    chk("abort.state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);
    do_read("after_abort", MEMORY, 64'h1000, 8'h0D, -1, 0, 64'h11, 8, -1);

    // reset mid-write keeps the words already written
    reqcyc = 1'b1;
    req    = 64'h3000;
    reqtag = {WRITE, MEMORY, 8'h0E};
    @(negedge clk);
    reqcyc = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      reqcyc = 1'b1;
      req    = 64'hC0DE_0000 + 64'(k);
      @(negedge clk);
      model_mem[line_of(64'h3000) * 8 + k] = 64'hC0DE_0000 + 64'(k);
    end
    reqcyc = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 3; k < BEATS; k++) model_mem[line_of(64'h3000) * 8 + k] = 64'h0;
    do_write("fill_rest", MEMORY, 64'h3200, 8'h0F, 64'h0, -1, 0);
    exp_q.delete();
    reqcyc = 1'b1;
    req    = 64'h3000;
    reqtag = {READ, MEMORY, 8'h10};
    @(negedge clk);
    reqcyc = 1'b0;
    repeat (RD_LAT) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("partial.word%0d", k), resp, 64'hC0DE_0000 + 64'(k));
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("partial.idle", 64'(dbg_state), 64'(ST_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
